board_scan_driver: RTL and testbench

BOARD_SCAN_DRIVER -- requirements
Module: board_scan_driver

---
 rtl/board_scan_driver.sv | 148 ++++++++++++++
 tb/tb_board_scan_driver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/board_scan_driver.sv
// Time-multiplexed scan driver for a 7-col x 6-row two-colour board plus a selector line.
// Each frame freezes a snapshot of the game state, then walks 7 scan lines with a blanking gap before each.
module board_scan_driver #(
  parameter int unsigned DWELL        = 4,
  parameter int unsigned BLANK        = 2,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [5:0][6:0] board0,
  input  logic [5:0][6:0] board1,
  input  logic [2:0]      positionOut,
  input  logic            currentPlayer,
  input  logic            weHaveAWinner,
  output logic [6:0]      rowSel,
  output logic [6:0]      redCols,
  output logic [6:0]      grnCols,
  output logic            frameStart,
  output logic            busy
);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
  localparam logic [7:0]  FRAMES     = 8'(BLINK_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_SNAP, S_BLANK, S_DRIVE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      line_q, line_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [7:0]      frame_q, frame_d;
  logic            phase_q, phase_d;
  logic [5:0][6:0] b0_q, b1_q;
  logic [2:0]      pos_q;
  logic            player_q, win_q;
  logic [6:0]      row_q, row_d, red_q, red_d, grn_q, grn_d;
  logic            fs_q, busy_q;
  logic [6:0]      sel;
  logic [2:0]      ridx;

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    phase_d = phase_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_SNAP;
      S_SNAP: begin
        state_d = S_BLANK;
        line_d  = 3'd0;
        cnt_d   = 16'd0;
        if (frame_q + 8'd1 == FRAMES) begin
          frame_d = 8'd0;
          phase_d = ~phase_q;
        end else begin
          frame_d = frame_q + 8'd1;
        end
      end
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = 16'd0;
          state_d = S_DRIVE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DRIVE: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = 16'd0;
          if (line_q == 3'd6) begin
            state_d = enable ? S_SNAP : S_IDLE;
          end else begin
            line_d  = line_q + 3'd1;
            state_d = S_BLANK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from next-state so they land in the register alongside the state.
  always_comb begin
    row_d = 7'd0;
    red_d = 7'd0;
    grn_d = 7'd0;
    sel   = 7'd0;
    ridx  = line_d - 3'd1;
    if (state_d == S_DRIVE) begin
      row_d = 7'd1 << line_d;
      if (line_d == 3'd0) begin
        if (pos_q != 3'd7 && !win_q && phase_q) sel = 7'd1 << pos_q;
        red_d = player_q ? 7'd0 : sel;
        grn_d = player_q ? sel : 7'd0;
      end else begin
        red_d = b0_q[ridx];
        grn_d = b1_q[ridx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      line_q   <= 3'd0;
      cnt_q    <= 16'd0;
      frame_q  <= 8'd0;
      phase_q  <= 1'b1;
      b0_q     <= '0;
      b1_q     <= '0;
      pos_q    <= 3'd0;
      player_q <= 1'b0;
      win_q    <= 1'b0;
      row_q    <= 7'd0;
      red_q    <= 7'd0;
      grn_q    <= 7'd0;
      fs_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      if (state_q == S_SNAP) begin
        b0_q     <= board0;
        b1_q     <= board1;
        pos_q    <= positionOut;
        player_q <= currentPlayer;
        win_q    <= weHaveAWinner;
      end
      row_q  <= row_d;
      red_q  <= red_d;
      grn_q  <= grn_d;
      fs_q   <= (state_d == S_SNAP);
      busy_q <= (state_d != S_IDLE);
    end
  end

  assign rowSel     = row_q;
  assign redCols    = red_q;
  assign grnCols    = grn_q;
  assign frameStart = fs_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_board_scan_driver.sv
// Bench for board_scan_driver: frame-position reference model checked every cycle,
// a static-board vector table, and directed blink / mid-frame / enable-drop / reset sequences.
module tb_board_scan_driver;
  localparam int DW = 4, BL = 2, BF = 2;
  localparam int SLOT = BL + DW;
  localparam int FLEN = 1 + 7 * SLOT;

  logic            clk = 1'b0;
  logic            rst, en;
  logic [5:0][6:0] b0, b1;
  logic [2:0]      pos;
  logic            pl, win;
  logic [6:0]      rowSel, redCols, grnCols;
  logic            frameStart, busy;

  board_scan_driver #(.DWELL(DW), .BLANK(BL), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(rst), .enable(en), .board0(b0), .board1(b1),
    .positionOut(pos), .currentPlayer(pl), .weHaveAWinner(win),
    .rowSel(rowSel), .redCols(redCols), .grnCols(grnCols),
    .frameStart(frameStart), .busy(busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, total = 0;

  // Reference model: frame position m_t (0 = snapshot cycle), frames started since reset m_n.
  bit              m_run = 0;
  int              m_t = 0, m_n = 0;
  logic [5:0][6:0] s_b0, s_b1;
  logic [2:0]      s_pos;
  logic            s_pl, s_win;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic cyc();
    int u, ln;
    logic [6:0] er, eg, ero, sel;
    logic ef, eb, ph;
    if (rst) begin
      m_run = 0; m_n = 0;
    end else if (!m_run) begin
      if (en) begin m_run = 1; m_t = 0; m_n++; end
    end else begin
      if (m_t == 0) begin s_b0 = b0; s_b1 = b1; s_pos = pos; s_pl = pl; s_win = win; end
      m_t++;
      if (m_t == FLEN) begin
        if (en) begin m_t = 0; m_n++; end else m_run = 0;
      end
    end
    @(posedge clk); #1;
    er = 0; eg = 0; ero = 0; ef = 0; eb = m_run;
    if (m_run && m_t == 0) ef = 1;
    else if (m_run) begin
      u = m_t - 1; ln = u / SLOT;
      if (u % SLOT >= BL) begin
        ero = 7'(1 << ln);
        if (ln == 0) begin
          ph  = ((m_n / BF) % 2) == 0;
          sel = (s_pos <= 6 && !s_win && ph) ? 7'(1 << s_pos) : 7'd0;
          er  = s_pl ? 7'd0 : sel;
          eg  = s_pl ? sel : 7'd0;
        end else begin
          er = s_b0[ln-1]; eg = s_b1[ln-1];
        end
      end
    end
    chk("cyc", {9'd0, rowSel, redCols, grnCols, frameStart, busy}, {9'd0, ero, er, eg, ef, eb});
  endtask

  task automatic run_to(input int t);
    bit hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      cyc();
      if (m_run && m_t == t) hit = 1;
    end
    if (!hit) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && m_run; k++) cyc();
    if (m_run) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1; en = 0; cyc(); rst = 0;
  endtask

  typedef struct {
    logic [5:0][6:0] b0, b1;
    logic [2:0]      pos;
    logic            pl, win;
    logic [6:0]      er[7], eg[7];
  } vec_t;
  vec_t tv[5];

  logic [6:0] bl_exp[6];
  int         cnt;

  initial begin
    rst = 1; en = 0; b0 = '0; b1 = '0; pos = 0; pl = 0; win = 0;
    for (int i = 0; i < 5; i++) begin
      tv[i].b0 = '0; tv[i].b1 = '0; tv[i].pos = 0; tv[i].pl = 0; tv[i].win = 0;
      for (int l = 0; l < 7; l++) begin tv[i].er[l] = 0; tv[i].eg[l] = 0; end
    end
    // Selector for player 0 plus corner cells
    tv[0].b0[5] = 7'b0000001; tv[0].b1[0] = 7'b1000000; tv[0].pos = 3;
    tv[0].er[0] = 7'h08; tv[0].er[6] = 7'h01; tv[0].eg[1] = 7'h40;
    // Selector for player 1
    tv[1] = tv[0]; tv[1].pl = 1; tv[1].pos = 0; tv[1].er[0] = 0; tv[1].eg[0] = 7'h01;
    // Winner suppresses selector only
    tv[2] = tv[0]; tv[2].win = 1; tv[2].er[0] = 0;
    // Out-of-range selector column
    tv[3] = tv[0]; tv[3].pl = 1; tv[3].pos = 7; tv[3].er[0] = 0;
    // Amber cells, selector in last column
    tv[4].b0[2] = 7'h55; tv[4].b1[2] = 7'h55; tv[4].b1[4] = 7'h2a; tv[4].pos = 6;
    tv[4].er[0] = 7'h40; tv[4].er[3] = 7'h55; tv[4].eg[3] = 7'h55; tv[4].eg[5] = 7'h2a;
    bl_exp = '{7'h08, 7'h00, 7'h00, 7'h08, 7'h08, 7'h00};

    do_reset();
    chk("reset_outs", {9'd0, rowSel, redCols, grnCols, frameStart, busy}, 32'd0);

    // Vector table: first frame after reset has blinkPhase=1
    for (int i = 0; i < 5; i++) begin
      do_reset();
      b0 = tv[i].b0; b1 = tv[i].b1; pos = tv[i].pos; pl = tv[i].pl; win = tv[i].win; en = 1;
      cyc();
      chk("tv_fs", {31'd0, frameStart}, 32'd1);
      for (int l = 0; l < 7; l++) begin
        run_to(1 + l * SLOT + BL);
        chk("tv_row", {25'd0, rowSel}, 32'(1 << l));
        chk("tv_red", {25'd0, redCols}, {25'd0, tv[i].er[l]});
        chk("tv_grn", {25'd0, grnCols}, {25'd0, tv[i].eg[l]});
      end
      en = 0; drain();
    end

    // Blink phase over six consecutive frames, plus frame period
    do_reset();
    b0 = tv[0].b0; b1 = tv[0].b1; pos = 3; pl = 0; win = 0; en = 1;
    cyc();
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      cyc(); cnt++;
      if (frameStart) break;
    end
    chk("period", cnt, FLEN);
    do_reset(); en = 1; cyc();
    for (int f = 0; f < 6; f++) begin
      run_to(1 + BL);
      chk("blink", {25'd0, redCols}, {25'd0, bl_exp[f]});
    end

    // Mid-frame board change shows up only in the next frame
    do_reset(); b0 = '0; b0[5] = 7'h01; en = 1; cyc();
    run_to(10); b0[5] = 7'h7f;
    run_to(1 + 6 * SLOT + BL);
    chk("midframe_old", {25'd0, redCols}, 32'h01);
    run_to(1 + 6 * SLOT + BL);
    chk("midframe_new", {25'd0, redCols}, 32'h7f);

    // Enable drop during line 3: frame completes, then idle
    run_to(1 + 3 * SLOT + BL + 1);
    en = 0; cnt = 0;
    for (int k = 0; k < 100; k++) begin
      cyc(); cnt++;
      if (!busy) break;
    end
    chk("drop_len", cnt, FLEN - (1 + 3 * SLOT + BL + 1));
    chk("drop_idle", {9'd0, rowSel, redCols, grnCols, frameStart, busy}, 32'd0);

    // Reset during DRIVE of line 4, then restart
    en = 1; cyc();
    run_to(1 + 4 * SLOT + BL + 1);
    rst = 1; cyc(); rst = 0;
    chk("rst_mid", {9'd0, rowSel, redCols, grnCols, frameStart, busy}, 32'd0);
    cyc();
    chk("restart_fs", {30'd0, frameStart, busy}, 32'd3);

    // Reset wins over enable
    rst = 1; en = 1; cyc();
    chk("rst_prio", {30'd0, frameStart, busy}, 32'd0);
    rst = 0;

    // Randomized stimulus, inputs churning every cycle
    for (int k = 0; k < 3000; k++) begin
      b0  = 42'({$urandom(), $urandom()});
      b1  = 42'({$urandom(), $urandom()});
      pos = 3'($urandom_range(0, 7));
      pl  = 1'($urandom_range(0, 1));
      win = ($urandom_range(0, 3) == 0);
      en  = ($urandom_range(0, 19) != 0);
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
